// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion, feeding the ALU.
// Optional BUBBLE_CNT_EN adds a saturating bubble_cnt output counting bubbles written.
module ex_operand_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_next,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [1:0]        id_src1_sel,
    input  logic              id_src2_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exm_reg_write,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_W-1:0]  mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
`ifdef BUBBLE_CNT_EN
    output logic [15:0]       bubble_cnt,
`endif
    output logic              load_use_stall
);

    localparam logic [3:0] OP_NOP     = 4'hF;
    localparam logic [1:0] SEL_RS     = 2'b00;
    localparam logic [1:0] SEL_RD_OLD = 2'b01;
    localparam logic [1:0] SEL_PC     = 2'b10;

    logic [3:0]        r_opcode;
    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_rs_data, r_rt_data, r_rd_old, r_imm, r_pc_next;
    logic [1:0]        r_src1_sel;
    logic              r_src2_imm, r_reg_write, r_mem_read, r_mem_write, r_valid;

    logic [DATA_W-1:0] fwd_rs, fwd_rt, fwd_rd_old;

    // Newest value of a register: EX/MEM beats MEM/WB beats the latched read; R0 is always zero.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_W-1:0]  idx,
        input logic [DATA_W-1:0] reg_data,
        input logic              e_we,
        input logic [REG_W-1:0]  e_rd,
        input logic [DATA_W-1:0] e_val,
        input logic              m_we,
        input logic [REG_W-1:0]  m_rd,
        input logic [DATA_W-1:0] m_val
    );
        logic [DATA_W-1:0] res;
        res = reg_data;
        if (idx == '0)                            res = '0;
        else if (e_we && e_rd != '0 && e_rd == idx) res = e_val;
        else if (m_we && m_rd != '0 && m_rd == idx) res = m_val;
        return res;
    endfunction

    assign fwd_rs     = fwd(r_rs, r_rs_data, exm_reg_write, exm_rd, exm_result,
                            mwb_reg_write, mwb_rd, mwb_data);
    assign fwd_rt     = fwd(r_rt, r_rt_data, exm_reg_write, exm_rd, exm_result,
                            mwb_reg_write, mwb_rd, mwb_data);
    assign fwd_rd_old = fwd(r_rd, r_rd_old, exm_reg_write, exm_rd, exm_result,
                            mwb_reg_write, mwb_rd, mwb_data);

    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_valid & r_reg_write;
    assign ex_mem_read   = r_valid & r_mem_read;
    assign ex_mem_write  = r_valid & r_mem_write;
    assign ex_rd         = r_rd;
    assign alu_opcode    = r_valid ? r_opcode : OP_NOP;
    assign ex_store_data = fwd_rt;
    assign alu_in2       = r_src2_imm ? r_imm : fwd_rt;

    always_comb begin
        alu_in1 = '0;
        case (r_src1_sel)
            SEL_RS:     alu_in1 = fwd_rs;
            SEL_RD_OLD: alu_in1 = fwd_rd_old;
            SEL_PC:     alu_in1 = r_pc_next;
            default:    alu_in1 = '0;
        endcase
    end

    // Dependent instruction in decode while a load sits in EX.
    assign load_use_stall = ex_mem_read && (r_rd != '0) && id_valid &&
                            ((id_use_rs && id_rs == r_rd) ||
                             (id_use_rt && id_rt == r_rd) ||
                             (id_src1_sel == SEL_RD_OLD && id_rd == r_rd));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode    <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_rd_old    <= '0;
            r_imm       <= '0;
            r_pc_next   <= '0;
            r_src1_sel  <= '0;
            r_src2_imm  <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_valid     <= 1'b0;
        end else if (flush || (!stall && load_use_stall)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_opcode    <= OP_NOP;
        end else if (!stall) begin
            r_opcode    <= id_opcode;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rd        <= id_rd;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_rd_old    <= (id_src1_sel == SEL_RD_OLD) ? id_rt_data : '0;
            r_imm       <= id_imm;
            r_pc_next   <= id_pc_next;
            r_src1_sel  <= id_src1_sel;
            r_src2_imm  <= id_src2_imm;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_valid     <= id_valid;
        end
    end

`ifdef BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bubble_cnt <= '0;
        else if ((flush || (!stall && load_use_stall)) && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_next;
    logic        id_use_rs, id_use_rt, id_src2_imm;
    logic [1:0]  id_src1_sel;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write, mwb_reg_write;
    logic [3:0]  exm_rd, mwb_rd;
    logic [15:0] exm_result, mwb_data;
    logic [3:0]  alu_opcode, ex_rd;
    logic [15:0] alu_in1, alu_in2, ex_store_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
`ifdef BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc_next(id_pc_next),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_src1_sel(id_src1_sel), .id_src2_imm(id_src2_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data),
`ifdef BUBBLE_CNT_EN
        .bubble_cnt(bubble_cnt),
`endif
        .load_use_stall(load_use_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc_next = 0;
        id_use_rs = 0; id_use_rt = 0; id_src1_sel = 0; id_src2_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic clear_fwd();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    initial begin
        rst = 0; stall = 0; flush = 0;
        clear_id();
        clear_fwd();
        step();
        step();
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_opcode", 32'(alu_opcode), 32'hF);
        chk("rst_in1", 32'(alu_in1), 32'h0);
        chk("rst_in2", 32'(alu_in2), 32'h0);
        chk("rst_lus", 32'(load_use_stall), 32'h0);
        rst = 1;

        // ADD R3,R1,R2
        id_valid = 1; id_opcode = 4'h0; id_rs = 1; id_rt = 2; id_rd = 3;
        id_rs_data = 5; id_rt_data = 7; id_use_rs = 1; id_use_rt = 1; id_reg_write = 1;
        step();
        chk("add_valid", 32'(ex_valid), 32'h1);
        chk("add_opcode", 32'(alu_opcode), 32'h0);
        chk("add_in1", 32'(alu_in1), 32'd5);
        chk("add_in2", 32'(alu_in2), 32'd7);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_rw", 32'(ex_reg_write), 32'h1);

        // Forwarding priority on the latched ADD
        clear_id();
        exm_reg_write = 1; exm_rd = 1; exm_result = 100;
        mwb_reg_write = 1; mwb_rd = 1; mwb_data = 50;
        #1;
        chk("fwd_exm_in1", 32'(alu_in1), 32'd100);
        chk("fwd_exm_in2", 32'(alu_in2), 32'd7);
        exm_rd = 2;
        #1;
        chk("fwd_mwb_in1", 32'(alu_in1), 32'd50);
        chk("fwd_exm_in2b", 32'(alu_in2), 32'd100);
        chk("fwd_store", 32'(ex_store_data), 32'd100);
        exm_reg_write = 0; mwb_rd = 2;
        #1;
        chk("fwd_none_in1", 32'(alu_in1), 32'd5);
        chk("fwd_mwb_in2", 32'(alu_in2), 32'd50);

        // Forward to R0 never happens
        clear_fwd();
        exm_reg_write = 1; exm_rd = 0; exm_result = 9;
        id_valid = 1; id_rs = 0; id_rs_data = 16'h0033; id_rt = 2; id_rt_data = 4;
        id_use_rs = 1; id_use_rt = 1; id_rd = 7; id_reg_write = 1;
        step();
        chk("r0_in1", 32'(alu_in1), 32'h0);
        chk("r0_in2", 32'(alu_in2), 32'd4);
        clear_fwd();

        // LW R4 then ADD R5,R4,R4
        clear_id();
        id_valid = 1; id_opcode = 4'h8; id_rs = 1; id_rs_data = 10; id_rd = 4;
        id_use_rs = 1; id_src2_imm = 1; id_imm = 2; id_mem_read = 1; id_reg_write = 1;
        step();
        chk("lw_mr", 32'(ex_mem_read), 32'h1);
        chk("lw_in1", 32'(alu_in1), 32'd10);
        chk("lw_in2", 32'(alu_in2), 32'd2);
        clear_id();
        id_valid = 1; id_opcode = 4'h0; id_rs = 4; id_rt = 4; id_rd = 5;
        id_rs_data = 16'h1111; id_rt_data = 16'h1111; id_use_rs = 1; id_use_rt = 1; id_reg_write = 1;
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'h1);
        step();
        chk("lu_bub_valid", 32'(ex_valid), 32'h0);
        chk("lu_bub_opcode", 32'(alu_opcode), 32'hF);
        chk("lu_bub_rw", 32'(ex_reg_write), 32'h0);
        chk("lu_stall_off", 32'(load_use_stall), 32'h0);
        mwb_reg_write = 1; mwb_rd = 4; mwb_data = 16'h0777;
        step();
        chk("lu_add_valid", 32'(ex_valid), 32'h1);
        chk("lu_add_in1", 32'(alu_in1), 32'h0777);
        chk("lu_add_in2", 32'(alu_in2), 32'h0777);
        chk("lu_add_rd", 32'(ex_rd), 32'd5);
        clear_fwd();

        // LLB R2 and rd-old forwarding
        clear_id();
        id_valid = 1; id_opcode = 4'hA; id_rd = 2; id_rt = 2; id_rt_data = 16'h1234;
        id_src1_sel = 2'b01; id_src2_imm = 1; id_imm = 16'h0056; id_reg_write = 1;
        step();
        chk("llb_in1", 32'(alu_in1), 32'h1234);
        chk("llb_in2", 32'(alu_in2), 32'h0056);
        exm_reg_write = 1; exm_rd = 2; exm_result = 16'hBEEF;
        #1;
        chk("llb_fwd_in1", 32'(alu_in1), 32'hBEEF);
        clear_fwd();

        // PCS, then src1_sel 11
        clear_id();
        id_valid = 1; id_opcode = 4'hE; id_src1_sel = 2'b10; id_pc_next = 16'h0042;
        id_src2_imm = 1; id_rd = 6; id_reg_write = 1;
        step();
        chk("pcs_in1", 32'(alu_in1), 32'h0042);
        id_src1_sel = 2'b11; id_rs = 1; id_rs_data = 16'h5555;
        step();
        chk("sel11_in1", 32'(alu_in1), 32'h0);

        // stall + flush together
        stall = 1; flush = 1;
        step();
        chk("sf_valid", 32'(ex_valid), 32'h0);
        chk("sf_opcode", 32'(alu_opcode), 32'hF);
`ifdef BUBBLE_CNT_EN
        chk("sf_bcnt", 32'(bubble_cnt), 32'd2);
`endif
        stall = 0; flush = 0;

        // stall alone holds for 3 cycles
        clear_id();
        id_valid = 1; id_opcode = 4'h1; id_rs = 1; id_rt = 2; id_rd = 3;
        id_rs_data = 3; id_rt_data = 4; id_use_rs = 1; id_use_rt = 1; id_reg_write = 1;
        step();
        chk("pre_stall_in1", 32'(alu_in1), 32'd3);
        stall = 1;
        id_opcode = 4'h2; id_rs_data = 16'h0099; id_rt_data = 16'h0088; id_rd = 9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(ex_valid), 32'h1);
            chk("stall_opcode", 32'(alu_opcode), 32'h1);
            chk("stall_in1", 32'(alu_in1), 32'd3);
            chk("stall_in2", 32'(alu_in2), 32'd4);
            chk("stall_rd", 32'(ex_rd), 32'd3);
        end
        stall = 0;

        // stall wins over load-use; bubble written once stall drops
        clear_id();
        id_valid = 1; id_opcode = 4'h8; id_rs = 1; id_rd = 6; id_src2_imm = 1;
        id_mem_read = 1; id_reg_write = 1;
        step();
        clear_id();
        id_valid = 1; id_opcode = 4'h0; id_rs = 6; id_use_rs = 1; id_rd = 7; id_reg_write = 1;
        stall = 1;
        #1;
        chk("slu_stall", 32'(load_use_stall), 32'h1);
        step();
        chk("slu_hold_mr", 32'(ex_mem_read), 32'h1);
        chk("slu_hold_rd", 32'(ex_rd), 32'd6);
        stall = 0;
        step();
        chk("slu_bub_valid", 32'(ex_valid), 32'h0);
`ifdef BUBBLE_CNT_EN
        chk("slu_bcnt", 32'(bubble_cnt), 32'd3);
`endif
        step();
        chk("slu_dep_valid", 32'(ex_valid), 32'h1);
        chk("slu_dep_rd", 32'(ex_rd), 32'd7);

        // asynchronous reset mid-stream
        clear_fwd();
        #2;
        rst = 0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'h0);
        chk("arst_opcode", 32'(alu_opcode), 32'hF);
        chk("arst_in1", 32'(alu_in1), 32'h0);
        chk("arst_in2", 32'(alu_in2), 32'h0);
`ifdef BUBBLE_CNT_EN
        chk("arst_bcnt", 32'(bubble_cnt), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
